// File: rtl/seg7_scan_driver_if.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver_if
// Input bundle from the counter/clock datapath into the 7-segment scan driver.
// Optional feature macro consumed by the driver: SEG7_BLINK_EN.
//   digits_in   [4*NUM_DIGITS]  packed 4-bit codes, [3:0] = digit 0 (rightmost)
//   dp_in       [NUM_DIGITS]    decimal point per digit, 1 = lit
//   load        1               capture digits_in/dp_in this cycle
//   lz_en       1               leading-zero suppression enable (live)
//   blink_mask  [NUM_DIGITS]    per-digit blink enable (live, blink builds only)
// master = datapath side (drives), slave = scan driver side (samples).
// ----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    lz_en;
    logic [NUM_DIGITS-1:0]   blink_mask;

    modport master (
        output digits_in,
        output dp_in,
        output load,
        output lz_en,
        output blink_mask
    );

    modport slave (
        input digits_in,
        input dp_in,
        input load,
        input lz_en,
        input blink_mask
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// A code word is latched as "pending" on load and committed to the display
// registers only at a frame boundary, so a frame never mixes two words.
// Optional feature: define SEG7_BLINK_EN for per-digit blinking with a
// half-period of BLINK_DIV frames.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   bus          seg7_scan_driver_if.slave: digits_in, dp_in, load, lz_en,
//                blink_mask
//   an_n         digit enables, active-low, one-hot-low while scanning
//   seg_n        segments a..g (index 0 = a), active-low
//   dp_n         decimal point of the active digit, active-low
//   frame_start  one-cycle pulse when the outputs switch to digit 0
// ----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned BLINK_DIV  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_scan_driver_if.slave     bus,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [0:6]            seg_n,
    output logic                  dp_n,
    output logic                  frame_start
);

    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(SCAN_DIV - 1);

    typedef logic [NUM_DIGITS-1:0][3:0] code_vec_t;

    // 4-bit code to active-low segments a..g; 0xA is a minus sign, B-F blank.
    function automatic logic [0:6] decode(input logic [3:0] code);
        logic [0:6] seg;
        case (code)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b1111110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Scan timing state
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             lit_q, lit_d;

    // Display and pending word state
    code_vec_t             disp_q, disp_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    code_vec_t             pend_q, pend_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_flag_q, pend_flag_d;

    // Registered outputs
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic [0:6]            seg_n_q, seg_n_d;
    logic                  dp_n_q, dp_n_d;
    logic                  frame_start_q, frame_start_d;

    logic tick;
    logic boundary;
    logic blink_phase_d;

    // Prescaler, digit index and pending/display word handling
    always_comb begin
        presc_d     = presc_q;
        idx_d       = idx_q;
        lit_d       = lit_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_flag_d = pend_flag_q;

        tick     = (presc_q == LAST_PRE);
        boundary = tick && (idx_q == LAST_IDX);

        presc_d = tick ? '0 : presc_q + PRE_W'(1);
        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
        // The first slot after reset stays dark; lighting starts at the first tick.
        lit_d = lit_q | tick;

        // Commit uses the old pending word, so a load on the boundary stays pending.
        if (boundary && pend_flag_q) begin
            disp_d      = pend_q;
            disp_dp_d   = pend_dp_q;
            pend_flag_d = 1'b0;
        end
        if (bus.load) begin
            pend_d      = code_vec_t'(bus.digits_in);
            pend_dp_d   = bus.dp_in;
            pend_flag_d = 1'b1;
        end
    end

`ifdef SEG7_BLINK_EN
    logic [BLINK_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               blink_phase_q;

    // Frame counter; blink phase flips each time it wraps
    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (boundary) begin
            if (frame_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`else
    logic unused_blink;

    assign blink_phase_d = 1'b0;
    assign unused_blink  = ^{bus.blink_mask, BLINK_W'(0)};
`endif

    // Next output values for the digit that will be active after this edge
    always_comb begin
        logic [NUM_DIGITS-1:0] lz_blank;
        logic                  zero_run;
        logic [3:0]            code;
        logic                  blank;
        logic                  hide;

        an_n_d        = '1;
        seg_n_d       = '1;
        dp_n_d        = 1'b1;
        frame_start_d = boundary;
        lz_blank      = '0;
        zero_run      = 1'b1;

        // Digit k blanks when it and every digit above it are zero; digit 0 never does.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run    = zero_run && (disp_d[k] == 4'h0);
            lz_blank[k] = bus.lz_en && zero_run && (k != 0);
        end

        code  = disp_d[idx_d];
        blank = lz_blank[idx_d];
        hide  = bus.blink_mask[idx_d] && blink_phase_d;

        if (lit_d) begin
            an_n_d  = ~(NUM_DIGITS'(1) << idx_d);
            seg_n_d = (blank || hide) ? 7'b1111111 : decode(code);
            dp_n_d  = hide ? 1'b1 : ~disp_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            idx_q         <= '0;
            lit_q         <= 1'b0;
            disp_q        <= '1;
            disp_dp_q     <= '0;
            pend_q        <= '1;
            pend_dp_q     <= '0;
            pend_flag_q   <= 1'b0;
            an_n_q        <= '1;
            seg_n_q       <= '1;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            lit_q         <= lit_d;
            disp_q        <= disp_d;
            disp_dp_q     <= disp_dp_d;
            pend_q        <= pend_d;
            pend_dp_q     <= pend_dp_d;
            pend_flag_q   <= pend_flag_d;
            an_n_q        <= an_n_d;
            seg_n_q       <= seg_n_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an_n        = an_n_q;
    assign seg_n       = seg_n_q;
    assign dp_n        = dp_n_q;
    assign frame_start = frame_start_q;

endmodule
